id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS core; sits directly upstream of the ALU.
- Latches decoded fields and control bits from decode.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Steers shift amounts and immediates into the ALU operand slots (oprd1, oprd2, option) and detects load-use hazards.

---
 rtl/id_ex_operand_if.sv | 53 +++++
 rtl/id_ex_operand_stage.sv | 76 +++++++
 tb/tb_id_ex_operand_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_if.sv
// id_ex_operand_if: decode, forwarding and ALU-operand signals around the ID/EX register
interface id_ex_operand_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          flush;
    logic          stall;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_shamt;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_dest;
    logic [3:0]    id_option;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;
    logic          id_mem_to_reg;
    logic          exm_reg_write;
    logic [RW-1:0] exm_dest;
    logic [DW-1:0] exm_result;
    logic          wb_reg_write;
    logic [RW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] oprd1;
    logic [DW-1:0] oprd2;
    logic [3:0]    option;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dest;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          load_use_stall;

    modport master (
        output flush, stall, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_dest,
               id_option, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exm_reg_write, exm_dest, exm_result, wb_reg_write, wb_dest, wb_data,
        input  oprd1, oprd2, option, ex_store_data, ex_dest, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, load_use_stall
    );

    modport slave (
        input  flush, stall, id_rs_data, id_rt_data, id_imm, id_shamt, id_rs, id_rt, id_dest,
               id_option, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exm_reg_write, exm_dest, exm_result, wb_reg_write, wb_dest, wb_data,
        output oprd1, oprd2, option, ex_store_data, ex_dest, ex_reg_write, ex_mem_read,
               ex_mem_write, ex_mem_to_reg, load_use_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with RAW forwarding, ALU operand steering and load-use detection
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic            clk,
    input logic            rst,
    id_ex_operand_if.slave bus
);
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef struct packed {
        logic [3:0]    op;
        logic          alu_src;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic [RW-1:0] dest;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [4:0]    shamt;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
    } ex_t;

    ex_t           ex_d, ex_q, id_fields;
    logic          lus;
    logic [DW-1:0] fwd_rs, fwd_rt, shamt_ext;

    // Next EX contents: flush beats stall; a load-use hazard inserts a bubble only when not holding
    always_comb begin
        id_fields = '{op: bus.id_option, alu_src: bus.id_alu_src, reg_write: bus.id_reg_write,
                      mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
                      mem_to_reg: bus.id_mem_to_reg, dest: bus.id_dest, rs: bus.id_rs,
                      rt: bus.id_rt, shamt: bus.id_shamt, rs_data: bus.id_rs_data,
                      rt_data: bus.id_rt_data, imm: bus.id_imm};
        lus = ex_q.mem_read && (ex_q.dest != '0) && (ex_q.dest == bus.id_rs || ex_q.dest == bus.id_rt);
        ex_d = (bus.flush || (!bus.stall && lus)) ? '0 : bus.stall ? ex_q : id_fields;
    end

    // Pipeline register; a reset and a bubble both clear every field
    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    // Forwarding from EX/MEM first, then MEM/WB; register 0 is never forwarded
    always_comb begin
        fwd_rs = (bus.exm_reg_write && bus.exm_dest != '0 && bus.exm_dest == ex_q.rs) ? bus.exm_result :
                 (bus.wb_reg_write && bus.wb_dest != '0 && bus.wb_dest == ex_q.rs) ? bus.wb_data : ex_q.rs_data;
        fwd_rt = (bus.exm_reg_write && bus.exm_dest != '0 && bus.exm_dest == ex_q.rt) ? bus.exm_result :
                 (bus.wb_reg_write && bus.wb_dest != '0 && bus.wb_dest == ex_q.rt) ? bus.wb_data : ex_q.rt_data;
        shamt_ext = {{(DW-5){1'b0}}, ex_q.shamt};
    end

    // Shifts take shamt in an operand slot; everything else is rs plus rt-or-immediate
    always_comb begin
        bus.oprd1 = (ex_q.op == OP_SLL || ex_q.op == OP_SRL) ? shamt_ext :
                    (ex_q.op == OP_SRA) ? fwd_rt : fwd_rs;
        bus.oprd2 = (ex_q.op == OP_SLL || ex_q.op == OP_SRL) ? fwd_rt :
                    (ex_q.op == OP_SRA) ? shamt_ext : ex_q.alu_src ? ex_q.imm : fwd_rt;
    end

    assign bus.option         = ex_q.op;
    assign bus.ex_store_data  = fwd_rt;
    assign bus.ex_dest        = ex_q.dest;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
    assign bus.load_use_stall = lus;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of the ID/EX operand stage against a reference model
module tb_id_ex_operand_stage;
    typedef struct packed {
        logic [3:0]  opt;
        logic        alu_src, rw, mr, mw, mtr;
        logic [4:0]  dest, rs, rt, shamt;
        logic [31:0] rsd, rtd, imm;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ins_t id = '0;
    ins_t m  = '0;
    logic exp_lus;
    int   errors = 0;
    int   checks = 0;

    id_ex_operand_if #(.DW(32), .RW(5)) bus ();

    id_ex_operand_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.id_option     = id.opt;
    assign bus.id_alu_src    = id.alu_src;
    assign bus.id_reg_write  = id.rw;
    assign bus.id_mem_read   = id.mr;
    assign bus.id_mem_write  = id.mw;
    assign bus.id_mem_to_reg = id.mtr;
    assign bus.id_dest       = id.dest;
    assign bus.id_rs         = id.rs;
    assign bus.id_rt         = id.rt;
    assign bus.id_shamt      = id.shamt;
    assign bus.id_rs_data    = id.rsd;
    assign bus.id_rt_data    = id.rtd;
    assign bus.id_imm        = id.imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf);
        if (bus.exm_reg_write && src != 0 && bus.exm_dest == src) return bus.exm_result;
        if (bus.wb_reg_write && src != 0 && bus.wb_dest == src) return bus.wb_data;
        return rf;
    endfunction

    task automatic check_all();
        logic [31:0] frs, frt, e1, e2;
        frs = fwd(m.rs, m.rsd);
        frt = fwd(m.rt, m.rtd);
        if (m.opt == 4'd4 || m.opt == 4'd5) begin e1 = 32'(m.shamt); e2 = frt; end
        else if (m.opt == 4'd10) begin e1 = frt; e2 = 32'(m.shamt); end
        else begin e1 = frs; e2 = m.alu_src ? m.imm : frt; end
        exp_lus = m.mr && m.dest != 0 && (m.dest == id.rs || m.dest == id.rt);
        chk("oprd1", bus.oprd1, e1);
        chk("oprd2", bus.oprd2, e2);
        chk("option", 32'(bus.option), 32'(m.opt));
        chk("store_data", bus.ex_store_data, frt);
        chk("ex_dest", 32'(bus.ex_dest), 32'(m.dest));
        chk("ctrl", {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg},
            {28'd0, m.rw, m.mr, m.mw, m.mtr});
        chk("load_use", 32'(bus.load_use_stall), 32'(exp_lus));
    endtask

    task automatic cyc();
        ins_t nxt;
        #1;
        check_all();
        nxt = m;
        if (rst || bus.flush || (!bus.stall && exp_lus)) nxt = '0;
        else if (!bus.stall) nxt = id;
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] ed, input logic [31:0] er,
                           input logic ww, input logic [4:0] wd, input logic [31:0] wv);
        bus.exm_reg_write = ew; bus.exm_dest = ed; bus.exm_result = er;
        bus.wb_reg_write = ww; bus.wb_dest = wd; bus.wb_data = wv;
    endtask

    initial begin
        logic [3:0] ops [6];
        ops = '{4'd0, 4'd4, 4'd5, 4'd10, 4'd13, 4'd2};
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        id = '{opt: 4'd7, alu_src: 1, rw: 1, mr: 1, mw: 1, mtr: 1, dest: 5'd9, rs: 5'd3, rt: 5'd4,
               shamt: 5'd7, rsd: 32'hdead, rtd: 32'hbeef, imm: 32'h77};
        @(posedge clk);
        #1;
        cyc();
        cyc();
        chk("rst_oprd1", bus.oprd1, 0);
        chk("rst_oprd2", bus.oprd2, 0);
        chk("rst_option", 32'(bus.option), 0);
        chk("rst_ctrl", {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 0);
        chk("rst_lus", 32'(bus.load_use_stall), 0);
        rst = 1'b0;

        id = '{opt: 4'd0, alu_src: 0, rw: 1, mr: 0, mw: 0, mtr: 0, dest: 5'd6, rs: 5'd3, rt: 5'd4,
               shamt: 5'd0, rsd: 32'd10, rtd: 32'd20, imm: 32'd0};
        cyc();
        id = '0;
        set_fwd(1, 3, 99, 1, 3, 55);
        #1;
        chk("fwd_exm_wins", bus.oprd1, 99);
        chk("fwd_rt_rf", bus.oprd2, 20);
        bus.exm_reg_write = 1'b0;
        #1;
        chk("fwd_wb", bus.oprd1, 55);
        id = '{opt: 4'd0, alu_src: 0, rw: 1, mr: 0, mw: 0, mtr: 0, dest: 5'd6, rs: 5'd0, rt: 5'd4,
               shamt: 5'd0, rsd: 32'd10, rtd: 32'd20, imm: 32'd0};
        set_fwd(1, 0, 99, 1, 0, 55);
        cyc();
        chk("fwd_r0", bus.oprd1, 10);
        set_fwd(0, 0, 0, 0, 0, 0);

        id = '{opt: 4'd4, alu_src: 0, rw: 1, mr: 0, mw: 0, mtr: 0, dest: 5'd8, rs: 5'd0, rt: 5'd7,
               shamt: 5'd4, rsd: 32'd0, rtd: 32'h1, imm: 32'd0};
        cyc();
        chk("sll_oprd1", bus.oprd1, 4);
        chk("sll_oprd2", bus.oprd2, 1);
        id.opt = 4'd10;
        id.rtd = 32'h8000_0000;
        cyc();
        chk("sra_oprd1", bus.oprd1, 32'h8000_0000);
        chk("sra_oprd2", bus.oprd2, 4);

        id = '{opt: 4'd0, alu_src: 1, rw: 1, mr: 1, mw: 0, mtr: 1, dest: 5'd5, rs: 5'd1, rt: 5'd5,
               shamt: 5'd0, rsd: 32'd100, rtd: 32'd0, imm: 32'd8};
        cyc();
        id = '{opt: 4'd0, alu_src: 0, rw: 1, mr: 0, mw: 0, mtr: 0, dest: 5'd6, rs: 5'd5, rt: 5'd2,
               shamt: 5'd0, rsd: 32'd1, rtd: 32'd2, imm: 32'd0};
        #1;
        chk("lu_stall", 32'(bus.load_use_stall), 1);
        cyc();
        chk("lu_bubble_ctrl", {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}, 0);
        chk("lu_bubble_dest", 32'(bus.ex_dest), 0);
        chk("lu_clear", 32'(bus.load_use_stall), 0);

        cyc();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id.dest = 5'(10 + i);
            id.rsd = $urandom;
            id.opt = 4'(i + 1);
            bus.exm_reg_write = 1'b1;
            bus.exm_dest = 5'd5;
            bus.exm_result = $urandom;
            cyc();
            chk("stall_dest", 32'(bus.ex_dest), 6);
            chk("stall_rw", 32'(bus.ex_reg_write), 1);
            chk("stall_fwd", bus.oprd1, bus.exm_result === 32'bx ? 0 : m.rs == 5 ? bus.exm_result : m.rsd);
        end
        bus.flush = 1'b1;
        cyc();
        chk("flush_stall_dest", 32'(bus.ex_dest), 0);
        chk("flush_stall_rw", 32'(bus.ex_reg_write), 0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        id.dest = 5'd9;
        cyc();
        bus.stall = 1'b1;
        rst = 1'b1;
        cyc();
        chk("rst_stall_dest", 32'(bus.ex_dest), 0);
        rst = 1'b0;
        bus.stall = 1'b0;

        id = '{opt: 4'd13, alu_src: 1, rw: 1, mr: 0, mw: 0, mtr: 0, dest: 5'd8, rs: 5'd0, rt: 5'd8,
               shamt: 5'd0, rsd: 32'd0, rtd: 32'd3, imm: 32'h1234};
        cyc();
        chk("lui_oprd2", bus.oprd2, 32'h1234);
        chk("lui_option", 32'(bus.option), 13);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.stall = ($urandom_range(0, 6) == 0);
            id.opt = ops[$urandom_range(0, 5)];
            id.alu_src = 1'($urandom);
            id.rw = 1'($urandom);
            id.mr = ($urandom_range(0, 2) == 0);
            id.mw = 1'($urandom);
            id.mtr = 1'($urandom);
            id.dest = 5'($urandom_range(0, 7));
            id.rs = 5'($urandom_range(0, 7));
            id.rt = 5'($urandom_range(0, 7));
            id.shamt = 5'($urandom);
            id.rsd = $urandom;
            id.rtd = $urandom;
            id.imm = $urandom;
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            cyc();
        end
        #1;
        check_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
